// File: rtl/register_file_sb.sv
// Multi-port register file with a per-register busy scoreboard.
// Reads are registered; same-cycle write forwarding and a hard-wired zero register are optional.
module register_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_RD-1:0]          i_rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   o_rd_data,
    output logic [NUM_RD-1:0]          o_rd_busy,
    input  logic [ADDR_W-1:0]          i_rw,
    input  logic [DATA_W-1:0]          i_bus_w,
    input  logic                       i_reg_wr,
    input  logic                       i_issue_en,
    input  logic [ADDR_W-1:0]          i_issue_addr,
    output logic                       o_stall
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [DATA_W-1:0] r_rd_data [NUM_RD];
    logic [NUM_RD-1:0] r_rd_busy;
    logic [NUM_RD-1:0] w_busy_eff;
    logic              w_wr_en;
    logic              w_issue_ok;

    // Register 0 swallows writes and issues when it is hard-wired.
    assign w_wr_en    = i_reg_wr && !((ZERO_REG != 0) && (i_rw == '0));
    assign w_issue_ok = i_issue_en && !((ZERO_REG != 0) && (i_issue_addr == '0));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[i_rw] <= i_bus_w;
        end
    end

    // Retire first, then issue, so a same-cycle re-issue leaves the register busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_reg_wr) begin
            w_busy_nxt[i_rw] = 1'b0;
        end
        if (w_issue_ok) begin
            w_busy_nxt[i_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        logic              w_zero;
        logic              w_fwd;
        logic [DATA_W-1:0] w_word;

        assign w_addr = i_rd_addr[i*ADDR_W +: ADDR_W];
        assign w_zero = (ZERO_REG != 0) && (w_addr == '0);
        assign w_fwd  = (BYPASS != 0) && i_reg_wr && (i_rw == w_addr) && !w_zero;
        assign w_word = w_zero ? '0 : (w_fwd ? i_bus_w : r_mem[w_addr]);
        assign w_busy_eff[i] = !w_zero && !w_fwd && r_busy[w_addr];

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_rd_data[i] <= '0;
                r_rd_busy[i] <= 1'b0;
            end else if (i_rd_en[i]) begin
                r_rd_data[i] <= w_word;
                r_rd_busy[i] <= w_busy_eff[i];
            end
        end

        assign o_rd_data[i*DATA_W +: DATA_W] = r_rd_data[i];
    end

    assign o_rd_busy = r_rd_busy;
    assign o_stall   = |(i_rd_en & w_busy_eff);

endmodule

// File: tb/tb_register_file_sb.sv
// Bench for register_file_sb: directed vector table, reset sequence, then random traffic
// against a reference model, driving a BYPASS=1 and a BYPASS=0 instance in parallel.
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic        reg_wr;
    logic [4:0]  rw;
    logic [31:0] bus_w;
    logic        issue_en;
    logic [4:0]  issue_addr;
    logic [63:0] rd_data, nb_rd_data;
    logic [1:0]  rd_busy, nb_rd_busy;
    logic        stall, nb_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_sb u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data), .o_rd_busy(rd_busy), .i_rw(rw), .i_bus_w(bus_w),
        .i_reg_wr(reg_wr), .i_issue_en(issue_en), .i_issue_addr(issue_addr), .o_stall(stall)
    );

    register_file_sb #(.BYPASS(0)) u_dut_nb (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(nb_rd_data), .o_rd_busy(nb_rd_busy), .i_rw(rw), .i_bus_w(bus_w),
        .i_reg_wr(reg_wr), .i_issue_en(issue_en), .i_issue_addr(issue_addr), .o_stall(nb_stall)
    );

    typedef struct {
        logic [1:0]  rd_en;
        logic [4:0]  ra0, ra1;
        logic        wr;
        logic [4:0]  rw;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ia;
        logic        exp_stall, exp_nb_stall;
        logic [31:0] exp_d0, exp_d1, exp_nb_d1;
        logic [1:0]  exp_busy;
    } vec_t;

    vec_t vecs[15];

    // Reference model: index 0 forwards writes, index 1 does not.
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    logic [31:0] m_rd   [2][2];
    logic        m_rb   [2][2];

    function automatic vec_t mk(logic [1:0] en, logic [4:0] a0, logic [4:0] a1, logic wr,
                                logic [4:0] w, logic [31:0] wd, logic iss, logic [4:0] ia,
                                logic st, logic nst, logic [31:0] d0, logic [31:0] d1,
                                logic [31:0] nd1, logic [1:0] b);
        vec_t v;
        v.rd_en = en; v.ra0 = a0; v.ra1 = a1; v.wr = wr; v.rw = w; v.wd = wd;
        v.iss = iss; v.ia = ia; v.exp_stall = st; v.exp_nb_stall = nst;
        v.exp_d0 = d0; v.exp_d1 = d1; v.exp_nb_d1 = nd1; v.exp_busy = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rd_en = '0; rd_addr = '0; reg_wr = 0; rw = '0; bus_w = '0; issue_en = 0; issue_addr = '0;
    endtask

    function automatic logic m_fwd(int v, logic [4:0] a);
        return (v == 0) && reg_wr && (rw == a) && (a != 0);
    endfunction

    function automatic logic m_eff_busy(int v, logic [4:0] a);
        if (a == 0 || m_fwd(v, a)) return 1'b0;
        return m_busy[v][a];
    endfunction

    function automatic logic [31:0] m_word(int v, logic [4:0] a);
        if (a == 0) return 32'h0;
        if (m_fwd(v, a)) return bus_w;
        return m_mem[v][a];
    endfunction

    function automatic logic m_stall(int v);
        for (int p = 0; p < 2; p++) begin
            if (rd_en[p] && m_eff_busy(v, rd_addr[p*5 +: 5])) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic m_reset();
        for (int v = 0; v < 2; v++) begin
            for (int a = 0; a < 32; a++) begin
                m_mem[v][a] = '0;
                m_busy[v][a] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                m_rd[v][p] = '0;
                m_rb[v][p] = 1'b0;
            end
        end
    endtask

    task automatic m_step();
        for (int v = 0; v < 2; v++) begin
            for (int p = 0; p < 2; p++) begin
                if (rd_en[p]) begin
                    m_rd[v][p] = m_word(v, rd_addr[p*5 +: 5]);
                    m_rb[v][p] = m_eff_busy(v, rd_addr[p*5 +: 5]);
                end
            end
            if (reg_wr && rw != 0) m_mem[v][rw] = bus_w;
            if (reg_wr) m_busy[v][rw] = 1'b0;
            if (issue_en && issue_addr != 0) m_busy[v][issue_addr] = 1'b1;
        end
    endtask

    initial begin
        vecs[0]  = mk(2'b00, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        vecs[1]  = mk(2'b01, 5, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF, 0, 0, 2'b00);
        vecs[2]  = mk(2'b10, 0, 7, 1, 7, 32'h1234, 0, 0, 0, 0, 32'hDEADBEEF, 32'h1234, 0, 2'b00);
        vecs[3]  = mk(2'b00, 0, 0, 0, 0, 0, 1, 3, 0, 0, 32'hDEADBEEF, 32'h1234, 0, 2'b00);
        vecs[4]  = mk(2'b01, 3, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0, 32'h1234, 0, 2'b01);
        vecs[5]  = mk(2'b01, 3, 0, 1, 3, 32'h55, 0, 0, 0, 1, 32'h55, 32'h1234, 0, 2'b00);
        vecs[6]  = mk(2'b00, 0, 0, 1, 9, 32'hAA, 1, 9, 0, 0, 32'h55, 32'h1234, 0, 2'b00);
        vecs[7]  = mk(2'b10, 0, 9, 0, 0, 0, 0, 0, 1, 1, 32'h55, 32'hAA, 32'hAA, 2'b10);
        vecs[8]  = mk(2'b00, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 32'h55, 32'hAA, 32'hAA, 2'b10);
        vecs[9]  = mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b00);
        vecs[10] = mk(2'b11, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b00);
        vecs[11] = mk(2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b00);
        vecs[12] = mk(2'b00, 0, 0, 0, 0, 0, 1, 9, 0, 0, 32'h0, 32'h0, 32'h0, 2'b00);
        vecs[13] = mk(2'b00, 0, 0, 1, 9, 32'hBB, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 2'b00);
        vecs[14] = mk(2'b01, 9, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBB, 32'h0, 32'h0, 2'b00);

        // Reset state
        idle_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rd_data lo", rd_data[31:0], 0);
        chk("reset rd_data hi", rd_data[63:32], 0);
        chk("reset rd_busy", {30'b0, rd_busy}, 0);
        chk("reset stall", {31'b0, stall}, 0);
        rst_n = 1;

        // Directed vectors
        for (int k = 0; k < 15; k++) begin
            rd_en = vecs[k].rd_en; rd_addr = {vecs[k].ra1, vecs[k].ra0};
            reg_wr = vecs[k].wr; rw = vecs[k].rw; bus_w = vecs[k].wd;
            issue_en = vecs[k].iss; issue_addr = vecs[k].ia;
            @(negedge clk);
            chk($sformatf("v%0d stall", k), {31'b0, stall}, {31'b0, vecs[k].exp_stall});
            chk($sformatf("v%0d nb stall", k), {31'b0, nb_stall}, {31'b0, vecs[k].exp_nb_stall});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d rd_data0", k), rd_data[31:0], vecs[k].exp_d0);
            chk($sformatf("v%0d rd_data1", k), rd_data[63:32], vecs[k].exp_d1);
            chk($sformatf("v%0d rd_busy", k), {30'b0, rd_busy}, {30'b0, vecs[k].exp_busy});
            chk($sformatf("v%0d nb rd_data1", k), nb_rd_data[63:32], vecs[k].exp_nb_d1);
        end

        // Asynchronous reset between edges discards everything, including a write in flight
        idle_inputs();
        reg_wr = 1; rw = 4; bus_w = 32'h99; issue_en = 1; issue_addr = 6;
        @(posedge clk);
        #1;
        idle_inputs();
        rd_en = 2'b11; rd_addr = {5'd6, 5'd4};
        @(posedge clk);
        #1;
        chk("pre-rst rd_data0", rd_data[31:0], 32'h99);
        chk("pre-rst rd_busy", {30'b0, rd_busy}, 32'h2);
        reg_wr = 1; rw = 4; bus_w = 32'h77;
        #2;
        rst_n = 0;
        #1;
        chk("async rst rd_data0", rd_data[31:0], 0);
        chk("async rst rd_busy", {30'b0, rd_busy}, 0);
        chk("async rst busy6 stall", {31'b0, stall}, 0);
        @(posedge clk);
        #1;
        rst_n = 1;
        reg_wr = 0;
        @(negedge clk);
        chk("post-rst stall", {31'b0, stall}, 0);
        @(posedge clk);
        #1;
        chk("post-rst r4", rd_data[31:0], 0);
        chk("post-rst r6 busy", {30'b0, rd_busy}, 0);

        // Random traffic against the model
        m_reset();
        idle_inputs();
        rst_n = 0;
        #2;
        rst_n = 1;
        for (int n = 0; n < 600; n++) begin
            rd_en      = 2'($urandom_range(0, 3));
            rd_addr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            reg_wr     = 1'($urandom_range(0, 1));
            rw         = 5'($urandom_range(0, 7));
            bus_w      = $urandom;
            issue_en   = ($urandom_range(0, 2) == 0);
            issue_addr = 5'($urandom_range(0, 7));
            @(negedge clk);
            chk($sformatf("rnd%0d stall", n), {31'b0, stall}, {31'b0, m_stall(0)});
            chk($sformatf("rnd%0d nb stall", n), {31'b0, nb_stall}, {31'b0, m_stall(1)});
            @(posedge clk);
            m_step();
            #1;
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rnd%0d data%0d", n, p), rd_data[p*32 +: 32], m_rd[0][p]);
                chk($sformatf("rnd%0d busy%0d", n, p), {31'b0, rd_busy[p]}, {31'b0, m_rb[0][p]});
                chk($sformatf("rnd%0d nb data%0d", n, p), nb_rd_data[p*32 +: 32], m_rd[1][p]);
                chk($sformatf("rnd%0d nb busy%0d", n, p), {31'b0, nb_rd_busy[p]},
                    {31'b0, m_rb[1][p]});
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
